// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs
// of the boot loader, bundled for connection between source, loader and core.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  InValid;
  logic [7:0]            InData;
  logic                  InReady;
  logic                  Reload;
  logic                  ImWr;
  logic [31:0]           ImAddr;
  logic [31:0]           ImData;
  logic                  CoreRun;
  logic                  Error;
  logic [ADDR_WIDTH:0]   WordsLoaded;

  modport slave (
    input  InValid, InData, Reload,
    output InReady, ImWr, ImAddr, ImData, CoreRun, Error, WordsLoaded
  );

  modport master (
    output InValid, InData, Reload,
    input  InReady, ImWr, ImAddr, ImData, CoreRun, Error, WordsLoaded
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream (length, LE words, checksum),
// writes instruction memory and releases the core only on a clean frame.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  localparam int          WLW   = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [23:0]    word_q, word_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic [7:0]     sum_q, sum_d;
  logic           imwr_q, imwr_d;
  logic [31:0]    imaddr_q, imaddr_d;
  logic [31:0]    imdata_q, imdata_d;
  logic           run_q, run_d;
  logic           err_q, err_d;
  logic [WLW-1:0] wl_q, wl_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] len_n;

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept   = bus.InValid && in_ready;
  assign len_n    = {bus.InData, len_q[7:0]};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    sum_d    = sum_q;
    imwr_d   = 1'b0;
    imaddr_d = imaddr_q;
    imdata_d = imdata_q;
    run_d    = run_q;
    err_d    = err_q;
    wl_d     = wl_q;

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.InData;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d  = len_n;
          sum_d  = '0;
          wl_d   = '0;
          bcnt_d = '0;
          if ({1'b0, len_n} > DEPTH) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_n == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          sum_d  = sum_q + bus.InData;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = bus.InData;
            2'd1: word_d[15:8]  = bus.InData;
            2'd2: word_d[23:16] = bus.InData;
            default: begin
              // Index < N <= DEPTH, so the low ADDR_WIDTH bits hold the whole word index.
              imwr_d   = 1'b1;
              imaddr_d = {{(30-ADDR_WIDTH){1'b0}}, wl_q[ADDR_WIDTH-1:0], 2'b00};
              imdata_d = {bus.InData, word_q};
              wl_d     = wl_q + 1'b1;
              if (17'(wl_q) + 17'd1 == 17'(len_q))
                state_d = S_CHECK;
            end
          endcase
        end
      end

      S_CHECK: begin
        if (accept) begin
          if (bus.InData == sum_q) begin
            state_d = S_RUN;
            run_d   = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      S_RUN, S_ERROR: begin
        if (bus.Reload) begin
          state_d = S_LEN_LO;
          run_d   = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
        end
      end

      default: state_d = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LEN_LO;
      len_q    <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      sum_q    <= '0;
      imwr_q   <= 1'b0;
      imaddr_q <= '0;
      imdata_q <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      wl_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      sum_q    <= sum_d;
      imwr_q   <= imwr_d;
      imaddr_q <= imaddr_d;
      imdata_q <= imdata_d;
      run_q    <= run_d;
      err_q    <= err_d;
      wl_q     <= wl_d;
    end
  end

  assign bus.InReady     = in_ready;
  assign bus.ImWr        = imwr_q;
  assign bus.ImAddr      = imaddr_q;
  assign bus.ImData      = imdata_q;
  assign bus.CoreRun     = run_q;
  assign bus.Error       = err_q;
  assign bus.WordsLoaded = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader (ADDR_WIDTH = 4, DEPTH = 16 words).
module tb_imem_loader;
  localparam int AW = 4;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          rl;
    bit          rdy;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          run;
    bit          err;
    int          wl;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit v, input logic [7:0] d, input bit rl,
                     input bit rdy, input bit wr, input logic [31:0] a,
                     input logic [31:0] dt, input bit run, input bit err, input int wl);
    vec_t e;
    e.v = v; e.d = d; e.rl = rl; e.rdy = rdy; e.wr = wr;
    e.addr = a; e.data = dt; e.run = run; e.err = err; e.wl = wl;
    tbl.push_back(e);
  endtask

  // Drive one cycle of inputs, then land 1 ns after the edge that consumed them.
  task automatic drive(input bit v, input logic [7:0] d, input bit rl);
    bus.InValid = v;
    bus.InData  = d;
    bus.Reload  = rl;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    bus.Reload  = 1'b0;
  endtask

  task automatic chk_state(input string tag, input bit rdy, input bit wr,
                           input bit run, input bit err, input int wl);
    chk({tag, "_rdy"}, 32'(bus.InReady), 32'(rdy));
    chk({tag, "_wr"},  32'(bus.ImWr),    32'(wr));
    chk({tag, "_run"}, 32'(bus.CoreRun), 32'(run));
    chk({tag, "_err"}, 32'(bus.Error),   32'(err));
    chk({tag, "_wl"},  32'(bus.WordsLoaded), 32'(wl));
  endtask

  initial begin
    // A: good single-word frame, then Reload out of RUN.
    add(1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h13, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 1, 32'h0, 32'h00000013, 0, 0, 1);
    add(1, 8'h13, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 8'h55, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // B: two words with gaps; Reload in LEN_HI ignored. Data byte sum 0xE3+0x24 = 0x07.
    add(1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'hAA, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h93, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h50, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 1, 32'h0, 32'h00500093, 0, 0, 1);
    add(0, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h13, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h10, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h00, 0, 1, 1, 32'h4, 32'h00100113, 0, 0, 2);
    add(0, 8'h07, 0, 1, 0, 0, 0, 0, 0, 2);
    add(1, 8'h07, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // C: bad checksum, byte ignored in ERROR, Reload recovers.
    add(1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h13, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 1, 32'h0, 32'h00000013, 0, 0, 1);
    add(1, 8'h14, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 8'h13, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // D: N = 0, checksum 00.
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // E: N = 17 > DEPTH, rejected right after LenHi.
    add(1, 8'h11, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // F: N = 16 = DEPTH, word i = i, checksum 0+1+..+15 = 0x78.
    add(1, 8'h10, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      add(1, 8'(i), 0, 1, 0, 0, 0, 0, 0, i);
      add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, i);
      add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, i);
      add(1, 8'h00, 0, 1, 1, 32'(4*i), 32'(i), 0, 0, i + 1);
    end
    add(1, 8'h78, 0, 0, 0, 0, 0, 1, 0, 16);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // G: second frame overwrites address 0 with a new word.
    add(1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h93, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 1, 32'h0, 32'h00000093, 0, 0, 1);
    add(1, 8'h93, 0, 0, 0, 0, 0, 1, 0, 1);

    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    bus.Reload  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_state("reset", 1, 0, 0, 0, 0);
    chk("reset_addr", bus.ImAddr, 32'h0);
    chk("reset_data", bus.ImData, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].rl);
      chk_state($sformatf("v%0d", i), tbl[i].rdy, tbl[i].wr, tbl[i].run, tbl[i].err, tbl[i].wl);
      if (tbl[i].wr) begin
        chk($sformatf("v%0d_addr", i), bus.ImAddr, tbl[i].addr);
        chk($sformatf("v%0d_data", i), bus.ImData, tbl[i].data);
      end
    end

    // Asynchronous reset two bytes into word 0: no write may escape for the partial word.
    drive(0, 8'h00, 1);
    drive(1, 8'h01, 0);
    drive(1, 8'h00, 0);
    drive(1, 8'h13, 0);
    drive(1, 8'h00, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_state("rstmid", 1, 0, 0, 0, 0);
    chk("rstmid_addr", bus.ImAddr, 32'h0);
    chk("rstmid_data", bus.ImData, 32'h0);
    bus.InValid = 1'b1;
    bus.InData  = 8'h00;
    @(posedge clk);
    #1;
    chk_state("rsthold", 1, 0, 0, 0, 0);
    bus.InValid = 1'b0;
    rst = 1'b0;

    // Fresh frame after reset: word 0x00001237, checksum 0x37+0x12 = 0x49.
    drive(1, 8'h01, 0);
    drive(1, 8'h00, 0);
    drive(1, 8'h37, 0);
    chk_state("fresh_b0", 1, 0, 0, 0, 0);
    drive(1, 8'h12, 0);
    drive(1, 8'h00, 0);
    drive(1, 8'h00, 0);
    chk_state("fresh_w0", 1, 1, 0, 0, 1);
    chk("fresh_addr", bus.ImAddr, 32'h0);
    chk("fresh_data", bus.ImData, 32'h00001237);
    drive(1, 8'h49, 0);
    chk_state("fresh_run", 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
